// File: rtl/psum_collector_pkg.sv
// psum_pkg: shared widths and the saturation helper for the psum collector.
//   PSUM_W  default psum input width (2N)
//   OUT_W   default result width
//   sat_u   clamp an unsigned value to `width` bits and report the clamp
package psum_pkg;

    localparam int N      = 8;
    localparam int PSUM_W = 2 * N;
    localparam int OUT_W  = 16;

    // Values wider than 64 bits are not expected anywhere in this block.
    function automatic logic [63:0] sat_u(input logic [63:0] value,
                                          input int unsigned width,
                                          output logic       sat);
        logic [63:0] max_v;
        max_v = (64'd1 << width) - 64'd1;
        sat   = value > max_v;
        return sat ? max_v : value;
    endfunction

endpackage

// File: rtl/psum_collector_if.sv
// psum_collector_if: psum input stream and result output stream.
//   in_valid/in_ready/in_data     producer (PE) -> collector
//   out_valid/out_ready/out_data  collector -> output-write stage
//   slave  : collector side
//   master : producer/consumer (environment) side
interface psum_collector_if #(
    parameter int PSUM_W = psum_pkg::PSUM_W,
    parameter int OUT_W  = psum_pkg::OUT_W
);
    logic              in_valid;
    logic              in_ready;
    logic [PSUM_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/psum_collector_fifo.sv
// psum_fifo: synchronous first-word-fall-through FIFO with registered storage.
//   clk, reset    clock, synchronous active-high reset
//   push, din     write (never issued when full)
//   pop           read (never issued when empty)
//   dout          head word; holds the last popped word (0 after reset) when empty
//   full, empty, count   occupancy status
module psum_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] last_q, last_d;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        if (push) begin
            mem_d[wr_q] = din;
            wr_d        = nxt(wr_q);
        end
        if (pop) begin
            last_d = mem_q[rd_q];
            rd_d   = nxt(rd_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign count = cnt_q;
    // Stale slots are never shown; an empty FIFO repeats the last word handed out.
    assign dout  = empty ? last_q : mem_q[rd_q];

endmodule

// File: rtl/psum_collector.sv
// psum_collector: sums ACC_LEN PE psums per output pixel, saturates to OUT_W,
// and buffers results in a FWFT FIFO with a valid/ready output.
//   clk, reset   clock, synchronous active-high reset
//   clear        drop the partial group in progress (same-cycle sample dropped)
//   bus          psum input stream and result output stream (slave side)
//   fifo_count   result FIFO occupancy
//   sat_flag     sticky, set when any result was clamped; cleared by reset only
// Build option: PSUM_QUANT_EN adds round-half-up >> SHIFT before saturation.
module psum_collector #(
    parameter int N       = 8,
    parameter int ACC_LEN = 9,
    parameter int DEPTH   = 4,
    parameter int OUT_W   = 16,
    parameter int SHIFT   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    psum_collector_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       sat_flag
);
    import psum_pkg::*;

    localparam int ACC_W = 2*N + $clog2(ACC_LEN);
    localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             full, empty, accept, last, push, pop, push_sat;
    logic [OUT_W-1:0] push_data;

    assign bus.in_ready = !full;
    assign accept       = bus.in_valid && !full && !clear;
    assign last         = (cnt_q == CNT_W'(ACC_LEN-1));
    assign push         = accept && last;
    assign pop          = bus.out_valid && bus.out_ready;
    assign sum          = acc_q + ACC_W'(bus.in_data);

`ifdef PSUM_QUANT_EN
    // One extra bit so the rounding add cannot wrap.
    logic [ACC_W:0] rnd, res;
    assign rnd = (ACC_W+1)'(1) << (SHIFT-1);
    assign res = ({1'b0, sum} + rnd) >> SHIFT;
`else
    logic [ACC_W-1:0] res;
    assign res = sum;
`endif

    always_comb begin
        push_data = OUT_W'(sat_u(64'(res), OUT_W, push_sat));
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            if (last) begin
                // Group closes here; the next group can start on the next cycle.
                acc_d = '0;
                cnt_d = '0;
                if (push_sat) sat_d = 1'b1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    psum_fifo #(.WIDTH(OUT_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (push_data),
        .pop   (pop),
        .dout  (bus.out_data),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign bus.out_valid = !empty;
    assign sat_flag      = sat_q;

endmodule

// File: tb/tb_psum_collector.sv
module tb_psum_collector;
    localparam int N = 8, ACC_LEN = 9, DEPTH = 4, OUT_W = 16, SHIFT = 4;
    localparam longint unsigned OMAX = (64'd1 << OUT_W) - 1;

    logic clk = 1'b0;
    logic reset, clear;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;
    logic sat_flag;

    always #5 clk = ~clk;

    psum_collector_if #(.PSUM_W(2*N), .OUT_W(OUT_W)) bus();

    psum_collector #(.N(N), .ACC_LEN(ACC_LEN), .DEPTH(DEPTH), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .bus        (bus.slave),
        .fifo_count (fifo_count),
        .sat_flag   (sat_flag)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: results as a queue, the group as a running total and sample count.
    longint unsigned m_q[$];
    longint unsigned m_acc, m_last;
    int              m_cnt;
    bit              m_sat;
    longint unsigned obs[$];   // values actually handed out by the DUT

    function automatic longint unsigned qexp(input longint unsigned s);
`ifdef PSUM_QUANT_EN
        return (s + (64'd1 << (SHIFT-1))) >> SHIFT;
`else
        return s;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_acc = 0; m_cnt = 0; m_sat = 0; m_last = 0;
    endtask

    // One clock: drive, check against model mid-cycle, then advance model at the edge.
    task automatic cyc(input bit v, input longint unsigned d, input bit c, input bit r, output bit acc);
        bit pop;
        longint unsigned res;
        bus.in_valid  = v;
        bus.in_data   = 16'(d);
        clear         = c;
        bus.out_ready = r;
        @(negedge clk);
        chk("in_ready",   bus.in_ready,  m_q.size() < DEPTH);
        chk("out_valid",  bus.out_valid, m_q.size() != 0);
        chk("out_data",   bus.out_data,  (m_q.size() != 0) ? m_q[0] : m_last);
        chk("fifo_count", fifo_count,    m_q.size());
        chk("sat_flag",   sat_flag,      m_sat);
        if (bus.out_valid && r) obs.push_back(bus.out_data);
        pop = (m_q.size() > 0) && r;
        acc = v && (m_q.size() < DEPTH) && !c;
        @(posedge clk);
        if (pop) m_last = m_q.pop_front();
        if (c) begin
            m_acc = 0; m_cnt = 0;
        end else if (acc) begin
            m_acc += d;
            m_cnt++;
            if (m_cnt == ACC_LEN) begin
                res = qexp(m_acc);
                if (res > OMAX) begin res = OMAX; m_sat = 1; end
                m_q.push_back(res);
                m_acc = 0; m_cnt = 0;
            end
        end
        #1;
    endtask

    task automatic feed(input longint unsigned d, input int n, input bit r);
        bit a;
        for (int k = 0; k < n; k++) begin
            a = 0;
            for (int g = 0; g < 20 && !a; g++) cyc(1, d, 0, r, a);
            if (!a) chk("accept_timeout", 0, 1);
        end
    endtask

    task automatic idle(input int n, input bit r);
        bit a;
        for (int k = 0; k < n; k++) cyc(0, 0, 0, r, a);
    endtask

    task automatic do_reset();
        reset = 1; bus.in_valid = 0; clear = 0;
        @(posedge clk); #1;
        reset = 0;
        model_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bit a, r;
        int stall, guard;
        reset = 1; clear = 0;
        bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;

        // Reset state
        chk("rst_count", fifo_count, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data",  bus.out_data, 0);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_sat",   sat_flag, 0);
        idle(2, 1);

        // Basic group, result visible one cycle after the last accept
        obs.delete();
        feed(1000, 9, 1);
        chk("basic_valid", bus.out_valid, 1);
        chk("basic_data",  bus.out_data, qexp(9000));
        idle(3, 1);
        chk("basic_n",   obs.size(), 1);
        chk("basic_sat", sat_flag, 0);

        // Saturation, sticky through two normal groups
        obs.delete();
        feed(65535, 9, 1);
        idle(2, 1);
        feed(1, 9, 1);
        feed(1, 9, 1);
        idle(3, 1);
        chk("sat_n", obs.size(), 3);
`ifdef PSUM_QUANT_EN
        chk("sat_data", obs[0], 36863);
        chk("sat_flag", sat_flag, 0);
`else
        chk("sat_data", obs[0], 65535);
        chk("sat_flag", sat_flag, 1);
`endif
        chk("sat_after1", obs[1], qexp(9));
        chk("sat_after2", obs[2], qexp(9));

        // Backpressure: 4 results fill the FIFO, group 5 stalls, then drain
        obs.delete();
        r = 0; stall = 0;
        for (int g = 1; g <= 5; g++) begin
            for (int k = 0; k < 9; k++) begin
                a = 0; guard = 0;
                while (!a && guard < 20) begin
                    cyc(1, g, 0, r, a);
                    if (!a) begin
                        stall++;
                        if (stall == 3) begin
                            chk("bp_count", fifo_count, 4);
                            chk("bp_ready", bus.in_ready, 0);
                            r = 1;
                        end
                    end
                    guard++;
                end
                if (!a) chk("bp_timeout", 0, 1);
            end
        end
        idle(8, 1);
        chk("bp_n", obs.size(), 5);
        for (int i = 0; i < 5 && i < obs.size(); i++)
            chk("bp_order", obs[i], qexp(9 * (i + 1)));

        // Clear mid-group: partial sum of 7s dropped
        obs.delete();
        feed(7, 5, 1);
        cyc(1, 7, 1, 1, a);
        feed(1, 9, 1);
        idle(3, 1);
        chk("clr_n", obs.size(), 1);
        if (obs.size() > 0) chk("clr_data", obs[0], qexp(9));

        // Reset mid-operation with 2 buffered results and a partial group
        feed(3, 18, 0);
        feed(3, 4, 0);
        chk("mr_pre_count", fifo_count, 2);
        do_reset();
        chk("mr_count", fifo_count, 0);
        chk("mr_valid", bus.out_valid, 0);
        chk("mr_sat",   sat_flag, 0);
        obs.delete();
        feed(2, 9, 1);
        idle(3, 1);
        chk("mr_n", obs.size(), 1);
        if (obs.size() > 0) chk("mr_data", obs[0], qexp(18));

        // Quantisation stimulus
        obs.delete();
        feed(100, 9, 1);
        idle(3, 1);
        chk("q_n", obs.size(), 1);
`ifdef PSUM_QUANT_EN
        if (obs.size() > 0) chk("q_data", obs[0], 56);
`else
        if (obs.size() > 0) chk("q_data", obs[0], 900);
`endif

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 3) != 0,
                ($urandom_range(0, 1) != 0) ? $urandom_range(0, 65535) : $urandom_range(0, 300),
                $urandom_range(0, 39) == 0,
                $urandom_range(0, 3) != 0, a);
        end
        idle(10, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
